// File: rtl/lb_link_pkg.sv
// Shared link-layer definitions for the HPIO loopback lane: state encoding,
// default control words and the CRC-8 step function shared with the RX deframer.
package lb_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRAIN   = 3'd1,
    ST_SYNC    = 3'd2,
    ST_SEQ     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CRC     = 3'd5
  } state_t;

  localparam logic [7:0] TRAIN_WORD_DEF = 8'h6B;
  localparam logic [7:0] SYNC_WORD_DEF  = 8'hBC;
  localparam logic [7:0] FILL_WORD_DEF  = 8'h00;
  localparam logic [7:0] IDLE_WORD_DEF  = 8'h00;
  localparam logic [7:0] CRC8_POLY      = 8'h07;

  // One byte of CRC-8 (poly 0x07, MSB first, no reflection).
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/lb_sync2.sv
// Two-flop synchronizer for a single quasi-static level (phy_rdy).
module lb_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lb_tx_framer.sv
// TX framer for the HPIO data lane: holds the lane quiet until the PHY is
// ready, sends a training burst, then frames source bytes as SYNC, SEQ, payload.
// Optional CRC-8 trailer per frame when LB_TX_CRC8_EN is defined.
module lb_tx_framer
  import lb_link_pkg::*;
#(
  parameter int unsigned TRAIN_LEN  = 256,
  parameter logic [7:0]  TRAIN_WORD = TRAIN_WORD_DEF,
  parameter logic [7:0]  SYNC_WORD  = SYNC_WORD_DEF,
  parameter logic [7:0]  FILL_WORD  = FILL_WORD_DEF,
  parameter logic [7:0]  IDLE_WORD  = IDLE_WORD_DEF,
  parameter int unsigned FRAME_LEN  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_rdy,
  input  logic        retrain_req,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        trained,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam int TCW = $clog2(TRAIN_LEN);
  localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_LEN - 1);
  localparam logic [7:0]     SLOT_LAST  = 8'(FRAME_LEN - 1);

  state_t         state;
  logic [TCW-1:0] train_cnt;
  logic [7:0]     slot_cnt;
  logic [7:0]     seq;
  logic           rdy_s;
  logic [7:0]     slot_word;
`ifdef LB_TX_CRC8_EN
  logic [7:0]     crc;
`endif

  lb_sync2 u_rdy_sync (
    .clk (clk),
    .rst (rst),
    .d   (phy_rdy),
    .q   (rdy_s)
  );

  // NOTE: s_ready is a continuous assign of the state compare, so no path
  // can leave it unassigned and infer a latch.
  assign s_ready   = (state == ST_PAYLOAD);
  assign slot_word = s_valid ? s_data : FILL_WORD;

  // Link FSM: the state in cycle N chooses the registered word for cycle N+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_data   <= IDLE_WORD;
      trained   <= 1'b0;
      underrun  <= 1'b0;
      frame_cnt <= '0;
      seq       <= '0;
      train_cnt <= '0;
      slot_cnt  <= '0;
`ifdef LB_TX_CRC8_EN
      crc       <= '0;
`endif
    end else begin
      // NOTE: every state register here uses <= so all branches read the
      // pre-edge values, matching the flops that synthesis builds.
      underrun <= 1'b0;
      if (state != ST_IDLE && !rdy_s) begin
        // PHY lost: abandon any partial frame, keep seq and frame_cnt.
        state   <= ST_IDLE;
        tx_data <= IDLE_WORD;
        trained <= 1'b0;
      end else if (state != ST_IDLE && retrain_req) begin
        // Quiet word for one cycle, then a full fresh training burst.
        state     <= ST_TRAIN;
        train_cnt <= '0;
        tx_data   <= IDLE_WORD;
        trained   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            tx_data <= IDLE_WORD;
            if (rdy_s) begin
              state     <= ST_TRAIN;
              train_cnt <= '0;
            end
          end
          ST_TRAIN: begin
            tx_data   <= TRAIN_WORD;
            train_cnt <= train_cnt + 1'b1;
            if (train_cnt == TRAIN_LAST) begin
              state   <= ST_SYNC;
              trained <= 1'b1;
            end
          end
          ST_SYNC: begin
            // Idle between frames until the source has a byte ready.
            if (s_valid) begin
              tx_data <= SYNC_WORD;
              state   <= ST_SEQ;
            end else begin
              tx_data <= IDLE_WORD;
            end
          end
          ST_SEQ: begin
            tx_data  <= seq;
            seq      <= seq + 8'd1;
            slot_cnt <= '0;
            state    <= ST_PAYLOAD;
`ifdef LB_TX_CRC8_EN
            crc      <= crc8_next(8'h00, seq);
`endif
          end
          ST_PAYLOAD: begin
            tx_data  <= slot_word;
            underrun <= !s_valid;
            slot_cnt <= slot_cnt + 8'd1;
`ifdef LB_TX_CRC8_EN
            crc      <= crc8_next(crc, slot_word);
            if (slot_cnt == SLOT_LAST) begin
              state <= ST_CRC;
            end
`else
            if (slot_cnt == SLOT_LAST) begin
              frame_cnt <= frame_cnt + 16'd1;
              state     <= ST_SYNC;
            end
`endif
          end
`ifdef LB_TX_CRC8_EN
          ST_CRC: begin
            tx_data   <= crc;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= ST_SYNC;
          end
`endif
          default: begin
            state   <= ST_IDLE;
            tx_data <= IDLE_WORD;
            trained <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
